// File: rtl/decode_issue.sv
// decode_issue: single-entry decode and issue stage.
//
// Decodes one 32-bit instruction per cycle, reads both source registers
// combinationally from the register file, checks a per-register busy
// scoreboard for hazards, and issues a registered payload to the ALU stage
// through a valid/ready handshake. Illegal encodings are consumed and
// flagged with a one-cycle pulse without disturbing the issue slot.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   in_valid/in_ready      fetch handshake; in_inst/in_pc carry the instruction
//   rf_raddr1/2, rf_rdata1/2  same-cycle register file read port
//   wb_valid, wb_reg       writeback retire, clears the busy bit of wb_reg
//   out_valid/out_ready    issue handshake toward the ALU stage
//   alu_sel, d1, d2, wr_en, wr_reg, is_branch, br_target  registered payload
//   illegal                one-cycle pulse when an illegal instruction is consumed
//   stall_cnt              saturating count of cycles lost to hazards
module decode_issue #(
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [31:0]        in_pc,
  output logic [3:0]         rf_raddr1,
  output logic [3:0]         rf_raddr2,
  input  logic [31:0]        rf_rdata1,
  input  logic [31:0]        rf_rdata2,
  input  logic               wb_valid,
  input  logic [3:0]         wb_reg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         alu_sel,
  output logic [31:0]        d1,
  output logic [31:0]        d2,
  output logic               wr_en,
  output logic [3:0]         wr_reg,
  output logic               is_branch,
  output logic [31:0]        br_target,
  output logic               illegal,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [3:0] TypeAluR   = 4'b0000;
  localparam logic [3:0] TypeAluI   = 4'b1000;
  localparam logic [3:0] TypeCmpR   = 4'b0010;
  localparam logic [3:0] TypeCmpI   = 4'b1010;
  localparam logic [3:0] TypeBranch = 4'b0110;

  // Bit n set means fn == n is legal for that type class.
  localparam logic [15:0] AluFnMask = 16'h7873;  // 0,1,4,5,6,11,12,13,14
  localparam logic [15:0] CmpFnMask = 16'h0F0F;  // 0,1,2,3,8,9,10,11
  localparam logic [15:0] BrFnMask  = 16'hE0E0;  // 5,6,7,13,14,15

  // Instruction fields
  logic [3:0]  fn, typ, rd, rs1, rs2;
  logic [31:0] imm_sext;

  assign fn       = in_inst[31:28];
  assign typ      = in_inst[27:24];
  assign rd       = in_inst[23:20];
  assign rs1      = in_inst[19:16];
  assign rs2      = in_inst[15:12];
  assign imm_sext = {{16{in_inst[15]}}, in_inst[15:0]};

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  // Decode results
  logic        dec_legal;
  logic        dec_uses_rs2;
  logic        dec_writes;
  logic        dec_branch;
  logic [4:0]  dec_alu_sel;
  logic [31:0] dec_d2;
  logic [31:0] dec_target;

  always_comb begin
    dec_legal    = 1'b0;
    dec_uses_rs2 = 1'b0;
    dec_writes   = 1'b0;
    dec_branch   = 1'b0;
    dec_alu_sel  = {1'b1, fn};
    dec_d2       = 32'd0;
    dec_target   = 32'd0;
    case (typ)
      TypeAluR: begin
        dec_legal    = AluFnMask[fn];
        dec_uses_rs2 = 1'b1;
        dec_writes   = 1'b1;
        dec_alu_sel  = {1'b0, fn};
        dec_d2       = rf_rdata2;
      end
      TypeAluI: begin
        dec_legal   = AluFnMask[fn];
        dec_writes  = 1'b1;
        dec_alu_sel = {1'b0, fn};
        dec_d2      = imm_sext;
      end
      TypeCmpR: begin
        dec_legal    = CmpFnMask[fn];
        dec_uses_rs2 = 1'b1;
        dec_writes   = 1'b1;
        dec_d2       = rf_rdata2;
      end
      TypeCmpI: begin
        dec_legal  = CmpFnMask[fn];
        dec_writes = 1'b1;
        dec_d2     = imm_sext;
      end
      TypeBranch: begin
        dec_legal  = BrFnMask[fn];
        dec_branch = 1'b1;
        // Word offset relative to the next sequential pc, wraps mod 2^32.
        dec_target = in_pc + 32'd4 + {imm_sext[29:0], 2'b00};
      end
      default: ;
    endcase
  end

  // State
  logic [15:0]        busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic               illegal_q, illegal_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [4:0]         alu_sel_q;
  logic [31:0]        d1_q, d2_q, br_target_q;
  logic               wr_en_q, is_branch_q;
  logic [3:0]         wr_reg_q;

  // Hazards look at pre-edge busy bits only: a writeback retiring this cycle
  // still blocks. Illegal instructions are never held back.
  logic hazard;
  logic accept;
  logic issue;

  assign hazard = dec_legal &&
                  (busy_q[rs1] ||
                   (dec_uses_rs2 && busy_q[rs2]) ||
                   (dec_writes && busy_q[rd]));

  assign in_ready = !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign issue    = accept && dec_legal;

  always_comb begin
    out_valid_d = out_valid_q;
    if (issue) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign illegal_d = accept && !dec_legal;

  // Clear first so a same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) begin
      busy_d[wb_reg] = 1'b0;
    end
    if (issue && dec_writes) begin
      busy_d[rd] = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && hazard && (stall_cnt_q != {STALL_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Payload only moves on a legal issue, so it holds under back-pressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_sel_q   <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      wr_en_q     <= 1'b0;
      wr_reg_q    <= '0;
      is_branch_q <= 1'b0;
      br_target_q <= '0;
    end else if (issue) begin
      alu_sel_q   <= dec_alu_sel;
      d1_q        <= rf_rdata1;
      d2_q        <= dec_d2;
      wr_en_q     <= dec_writes;
      wr_reg_q    <= dec_writes ? rd : 4'd0;
      is_branch_q <= dec_branch;
      br_target_q <= dec_target;
    end
  end

  assign out_valid = out_valid_q;
  assign illegal   = illegal_q;
  assign stall_cnt = stall_cnt_q;
  assign alu_sel   = alu_sel_q;
  assign d1        = d1_q;
  assign d2        = d2_q;
  assign wr_en     = wr_en_q;
  assign wr_reg    = wr_reg_q;
  assign is_branch = is_branch_q;
  assign br_target = br_target_q;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_decode_issue;

  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_inst;
  logic [31:0]   in_pc;
  logic [3:0]    rf_raddr1, rf_raddr2;
  logic [31:0]   rf_rdata1, rf_rdata2;
  logic          wb_valid;
  logic [3:0]    wb_reg;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    alu_sel;
  logic [31:0]   d1, d2;
  logic          wr_en;
  logic [3:0]    wr_reg;
  logic          is_branch;
  logic [31:0]   br_target;
  logic          illegal;
  logic [SW-1:0] stall_cnt;

  decode_issue #(.STALL_W(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_sel   (alu_sel),
    .d1        (d1),
    .d2        (d2),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .is_branch (is_branch),
    .br_target (br_target),
    .illegal   (illegal),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    rf_rdata1 = '0;
    rf_rdata2 = '0;
    wb_valid  = 1'b0;
    wb_reg    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [4:0]  sel;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        wen;
    logic [3:0]  wreg;
    logic        br;
    logic [31:0] tgt;
  } pay_t;

  function automatic bit m_legal(input logic [31:0] inst);
    int f = int'(inst[31:28]);
    int t = int'(inst[27:24]);
    case (t)
      0, 8:    return f inside {0, 1, 4, 5, 6, 11, 12, 13, 14};
      2, 10:   return f inside {0, 1, 2, 3, 8, 9, 10, 11};
      6:       return f inside {5, 6, 7, 13, 14, 15};
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_writes(input logic [31:0] inst);
    return int'(inst[27:24]) inside {0, 8, 2, 10};
  endfunction

  function automatic bit m_uses_rs2(input logic [31:0] inst);
    return int'(inst[27:24]) inside {0, 2};
  endfunction

  function automatic pay_t m_decode(input logic [31:0] inst, input logic [31:0] pc,
                                    input logic [31:0] r1, input logic [31:0] r2);
    pay_t p;
    int t   = int'(inst[27:24]);
    int f   = int'(inst[31:28]);
    int imm = int'($signed(inst[15:0]));
    p.sel  = (t == 0 || t == 8) ? 5'(f) : 5'(16 + f);
    p.d1   = r1;
    p.d2   = (t == 0 || t == 2) ? r2 : (t == 8 || t == 10) ? 32'(imm) : 32'd0;
    p.wen  = m_writes(inst);
    p.wreg = p.wen ? inst[23:20] : 4'd0;
    p.br   = (t == 6);
    p.tgt  = p.br ? pc + 32'd4 + 32'(imm * 4) : 32'd0;
    return p;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  sel;
    logic [31:0] d2;
    logic        wen;
    logic [3:0]  wreg;
    logic        br;
    logic [31:0] tgt;
    logic        ill;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [15:0] bv;
    pay_t        mp;
    bit          mb[16];
    logic        m_ov, m_ill;
    int          m_stall;

    vecs[0]  = '{32'h0831FFFE, 32'h0, 32'd5, 32'h77, 5'h00, 32'hFFFFFFFE, 1'b1, 4'd3, 1'b0,
                 32'h0, 1'b0};
    vecs[1]  = '{32'h56020003, 32'h100, 32'h11, 32'h22, 5'h15, 32'h0, 1'b0, 4'd0, 1'b1,
                 32'h110, 1'b0};
    vecs[2]  = '{32'h32712000, 32'h0, 32'h1234, 32'hDEAD, 5'h13, 32'hDEAD, 1'b1, 4'd7, 1'b0,
                 32'h0, 1'b0};
    vecs[3]  = '{32'h9A817FFF, 32'h0, 32'h1, 32'h2, 5'h19, 32'h00007FFF, 1'b1, 4'd8, 1'b0,
                 32'h0, 1'b0};
    vecs[4]  = '{32'hF603FFFF, 32'h200, 32'h3, 32'h4, 5'h1F, 32'h0, 1'b0, 4'd0, 1'b1,
                 32'h200, 1'b0};
    vecs[5]  = '{32'h56010001, 32'hFFFFFFFC, 32'h5, 32'h6, 5'h15, 32'h0, 1'b0, 4'd0, 1'b1,
                 32'h4, 1'b0};
    vecs[6]  = '{32'hE0A12000, 32'h0, 32'hAAAA5555, 32'h0F0F0F0F, 5'h0E, 32'h0F0F0F0F, 1'b1,
                 4'd10, 1'b0, 32'h0, 1'b0};
    vecs[7]  = '{32'h20312000, 32'h0, 32'h1, 32'h1, 5'h0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1};
    vecs[8]  = '{32'h06010000, 32'h0, 32'h1, 32'h1, 5'h0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1};
    vecs[9]  = '{32'h2F000000, 32'h0, 32'h1, 32'h1, 5'h0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1};
    vecs[10] = '{32'h42312000, 32'h0, 32'h1, 32'h1, 5'h0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1};

    // Reset is asynchronous: outputs clear before the first clock edge.
    reset = 1'b1;
    #1;
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_stall_cnt", stall_cnt, 0);
    chk("rst_async_busy", dut.busy_q, 0);
    chk("rst_async_illegal", illegal, 0);

    // ---- vector table ----
    for (int i = 0; i < 11; i++) begin
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_inst   = vecs[i].inst;
      in_pc     = vecs[i].pc;
      rf_rdata1 = vecs[i].r1;
      rf_rdata2 = vecs[i].r2;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      chk($sformatf("vec%0d_raddr1", i), rf_raddr1, vecs[i].inst[19:16]);
      chk($sformatf("vec%0d_raddr2", i), rf_raddr2, vecs[i].inst[15:12]);
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", i), out_valid, !vecs[i].ill);
      chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill);
      if (!vecs[i].ill) begin
        chk($sformatf("vec%0d_alu_sel", i), alu_sel, vecs[i].sel);
        chk($sformatf("vec%0d_d1", i), d1, vecs[i].r1);
        chk($sformatf("vec%0d_d2", i), d2, vecs[i].d2);
        chk($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].wen);
        chk($sformatf("vec%0d_wr_reg", i), wr_reg, vecs[i].wreg);
        chk($sformatf("vec%0d_is_branch", i), is_branch, vecs[i].br);
        if (vecs[i].br) chk($sformatf("vec%0d_br_target", i), br_target, vecs[i].tgt);
      end
      bv = vecs[i].wen ? (16'd1 << vecs[i].wreg) : 16'd0;
      chk($sformatf("vec%0d_busy", i), dut.busy_q, bv);
      step();
      chk($sformatf("vec%0d_illegal_pulse_end", i), illegal, 0);
    end

    // ---- RAW hazard, no bypass from writeback ----
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'h00412000;   // ADD r4,r1,r2
    #1;
    chk("raw_first_ready", in_ready, 1);
    step();
    in_inst = 32'h10541000;     // SUB r5,r4,r1
    #1;
    chk("raw_first_issued", out_valid, 1);
    chk("raw_busy4", dut.busy_q, 16'h0010);
    chk("raw_stall_ready", in_ready, 0);
    step();
    chk("raw_stall_cnt1", stall_cnt, 1);
    chk("raw_ov_drained", out_valid, 0);
    step();
    wb_valid = 1'b1;
    wb_reg   = 4'd4;
    #1;
    chk("raw_no_bypass", in_ready, 0);
    step();
    wb_valid = 1'b0;
    #1;
    chk("raw_stall_cnt3", stall_cnt, 3);
    chk("raw_ready_after_wb", in_ready, 1);
    step();
    chk("raw_second_issued", out_valid, 1);
    chk("raw_second_wr_reg", wr_reg, 5);
    chk("raw_second_alu_sel", alu_sel, 5'h01);
    chk("raw_busy5", dut.busy_q, 16'h0020);
    chk("raw_stall_hold", stall_cnt, 3);

    // ---- illegal while a register is busy ----
    in_inst = 32'h2F000000;
    #1;
    chk("ill_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("ill_pulse", illegal, 1);
    chk("ill_ov", out_valid, 0);
    chk("ill_busy", dut.busy_q, 16'h0020);
    chk("ill_payload", wr_reg, 5);
    step();
    chk("ill_pulse_one_cycle", illegal, 0);

    // ---- back-pressure ----
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'h0831FFFE;
    rf_rdata1 = 32'd5;
    #1;
    step();
    out_ready = 1'b0;
    in_inst   = 32'h00612000;   // ADD r6,r1,r2, independent of r3
    rf_rdata1 = 32'd9;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d_ready", k), in_ready, 0);
      chk($sformatf("bp%0d_ov", k), out_valid, 1);
      chk($sformatf("bp%0d_d1", k), d1, 5);
      chk($sformatf("bp%0d_d2", k), d2, 32'hFFFFFFFE);
      chk($sformatf("bp%0d_wr_reg", k), wr_reg, 3);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_next_ov", out_valid, 1);
    chk("bp_next_wr_reg", wr_reg, 6);
    chk("bp_next_d1", d1, 9);
    chk("bp_next_busy", dut.busy_q, 16'h0048);

    // ---- stall saturation, then reset mid-stall ----
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00412000;
    #1;
    step();
    in_inst = 32'h10541000;
    #1;
    chk("rs_stall_ready", in_ready, 0);
    repeat (18) step();
    chk("rs_stall_saturated", stall_cnt, 15);
    chk("rs_ov_before", out_valid, 1);
    chk("rs_busy_before", dut.busy_q, 16'h0010);
    reset = 1'b1;
    #1;
    chk("rs_ov_async", out_valid, 0);
    chk("rs_busy_async", dut.busy_q, 0);
    chk("rs_stall_async", stall_cnt, 0);
    chk("rs_payload_async", wr_reg, 0);
    step();
    reset = 1'b0;
    #1;
    chk("rs_no_accept_in_reset", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("rs_first_accept", out_valid, 1);
    chk("rs_first_wr_reg", wr_reg, 5);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int j = 0; j < 16; j++) mb[j] = 1'b0;
    m_ov    = 1'b0;
    m_ill   = 1'b0;
    m_stall = 0;
    mp      = '{5'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0};
    for (int c = 0; c < 3000; c++) begin
      int   pick, rs1, rs2, rd;
      logic [3:0] t;
      bit   lg, hz, rdy, acc;
      pick = int'($urandom_range(0, 5));
      case (pick)
        0:       t = 4'd0;
        1:       t = 4'd8;
        2:       t = 4'd2;
        3:       t = 4'd10;
        4:       t = 4'd6;
        default: t = 4'($urandom);
      endcase
      in_inst   = {4'($urandom), t, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                   1'b0, 3'($urandom), 12'($urandom)};
      in_pc     = $urandom & 32'hFFFFFFFC;
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_reg    = 4'($urandom_range(0, 7));
      #1;
      lg  = m_legal(in_inst);
      rs1 = int'(in_inst[19:16]);
      rs2 = int'(in_inst[15:12]);
      rd  = int'(in_inst[23:20]);
      hz  = lg && (mb[rs1] || (m_uses_rs2(in_inst) && mb[rs2]) ||
                   (m_writes(in_inst) && mb[rd]));
      rdy = !hz && (!m_ov || out_ready);
      acc = in_valid && rdy;
      for (int j = 0; j < 16; j++) bv[j] = mb[j];
      chk("rnd_in_ready", in_ready, rdy);
      chk("rnd_out_valid", out_valid, m_ov);
      chk("rnd_illegal", illegal, m_ill);
      chk("rnd_stall_cnt", stall_cnt, m_stall);
      chk("rnd_busy", dut.busy_q, bv);
      chk("rnd_alu_sel", alu_sel, mp.sel);
      chk("rnd_d1", d1, mp.d1);
      chk("rnd_d2", d2, mp.d2);
      chk("rnd_wr", {wr_en, wr_reg}, {mp.wen, mp.wreg});
      chk("rnd_is_branch", is_branch, mp.br);
      if (mp.br) chk("rnd_br_target", br_target, mp.tgt);
      // advance the model across the coming edge
      m_ill = acc && !lg;
      if (acc && lg) begin
        mp   = m_decode(in_inst, in_pc, rf_rdata1, rf_rdata2);
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (in_valid && hz && m_stall < 15) m_stall++;
      if (wb_valid) mb[wb_reg] = 1'b0;
      if (acc && lg && m_writes(in_inst)) mb[rd] = 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have parameter STALL_W, default 16, width of the saturating stall counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1: a fetched instruction is presented.
REQ-005 SHALL have port in_ready, output, 1: the instruction is accepted this cycle.
REQ-006 SHALL have port in_inst, input, 32: instruction word. Fields: [31:28] fn, [27:24] type, [23:20] rd, [19:16] rs1, [15:12] rs2, [15:0] imm16.
REQ-007 SHALL have port in_pc, input, 32: address of in_inst.
REQ-008 SHALL have ports rf_raddr1 and rf_raddr2, output, 4 each: combinational copies of in_inst[19:16] and in_inst[15:12].
REQ-009 SHALL have ports rf_rdata1 and rf_rdata2, input, 32 each: same-cycle register file read data.
REQ-010 SHALL have ports wb_valid (input, 1) and wb_reg (input, 4): writeback retires a write to wb_reg.
REQ-011 SHALL have port out_valid, output, 1, and port out_ready, input, 1: the issue handshake toward the ALU stage.
REQ-012 SHALL have registered outputs alu_sel (5), d1 (32), d2 (32), wr_en (1), wr_reg (4), is_branch (1) and br_target (32).
REQ-013 SHALL have registered outputs illegal (1) and stall_cnt (STALL_W).

Function
REQ-014 SHALL support these type codes: ALUR 0000, ALUI 1000, CMPR 0010, CMPI 1010, BRANCH 0110.
- Legal fn for ALU types: 0, 1, 4, 5, 6, 11, 12, 13, 14.
- Legal fn for CMP types: 0, 1, 2, 3, 8, 9, 10, 11.
- Legal fn for BRANCH: 5, 6, 7, 13, 14, 15.
- Every other type/fn combination SHALL be illegal.
REQ-015 SHALL generate alu_sel as follows: {1'b0, fn} for ALU types; {1'b1, fn} for CMP and BRANCH types.
REQ-016 SHALL select operands as follows:
- d1 = rf_rdata1 for all types.
- d2 = rf_rdata2 for ALUR and CMPR.
- d2 = sign-extended imm16 for ALUI and CMPI.
- d2 = 0 for BRANCH.
REQ-017 SHALL set wr_en=1 and wr_reg=rd for ALU and CMP types, and wr_en=0 and wr_reg=0 for BRANCH.
REQ-018 SHALL set is_branch=1 for BRANCH, with br_target = in_pc + 4 + (sext(imm16) << 2), computed modulo 2^32.
REQ-019 SHALL keep a 16-bit busy scoreboard, one bit per register.
REQ-020 SHALL stall (hazard) when any of the following is true:
- busy[rs1] is set, for any type;
- busy[rs2] is set, for ALUR and CMPR;
- busy[rd] is set, for a writing type.
Illegal instructions SHALL never stall.
REQ-021 SHALL drive in_ready = !hazard && (!out_valid || out_ready); acceptance means in_valid && in_ready.
REQ-022 SHALL, on accepting a legal instruction:
- load every output payload field next edge;
- set out_valid=1;
- set busy[rd] if wr_en.
Issue latency is 1 cycle.
REQ-023 SHALL, on accepting an illegal instruction:
- consume it;
- pulse illegal=1 for exactly one cycle;
- leave out_valid, the payload and busy unchanged by it.
REQ-024 SHALL clear out_valid when out_ready=1 and no new legal instruction is accepted the same cycle.
REQ-025 SHALL hold the payload stable while out_valid=1 and out_ready=0.
REQ-026 SHALL clear busy[wb_reg] when wb_valid=1. If the same register is set and cleared in one cycle, it SHALL end busy=1.
REQ-027 SHALL evaluate hazards on pre-edge busy values: a register cleared this cycle still blocks this cycle (no bypass).
REQ-028 SHALL increment stall_cnt each cycle with in_valid=1 and hazard=1, saturating at all-ones.

Reset
REQ-029 SHALL, while reset=1, asynchronously force the following to 0: out_valid, all payload outputs, illegal, stall_cnt and all busy bits.
REQ-030 SHALL discard any instruction that is in flight when reset asserts; the first acceptance SHALL occur no earlier than the first edge after reset deasserts.

Verification
REQ-031 SHALL cover ADDI r3,r1,-2: in_inst=0x0831FFFE, rf_rdata1=5 -> next cycle out_valid=1, alu_sel=00000, d1=5, d2=0xFFFFFFFE, wr_en=1, wr_reg=3, busy[3]=1.
REQ-032 SHALL cover BEQZ r2: in_inst=0x56020003, in_pc=0x100 -> alu_sel=10101, d2=0, is_branch=1, br_target=0x110, wr_en=0, no busy bit set.
REQ-033 SHALL cover a RAW hazard: 0x00412000 (ADD r4,r1,r2), then 0x10541000 (SUB r5,r4,r1) with out_ready=1 -> the second instruction stalls with in_ready=0 and stall_cnt counting; after wb_valid=1, wb_reg=4 it issues one cycle later.
REQ-034 SHALL cover an illegal instruction: in_inst=0x2F000000 (type 1111) -> in_ready=1, illegal pulses for 1 cycle, out_valid unchanged, busy unchanged.
REQ-035 SHALL cover back-pressure: out_ready=0 for 3 cycles with out_valid=1 -> payload constant, in_ready=0; when out_ready rises, the next instruction is accepted in that cycle.
REQ-036 SHALL cover reset mid-stall: assert reset with out_valid=1 and busy[4]=1 -> out_valid=0, busy=0, stall_cnt=0 immediately, without waiting for a clock edge.
